// File: rtl/packet_route_port.sv
// packet_route_port: input FIFO feeding a registered XY-route output stage for one mesh port.
// Build option `SELF_DROP_EN discards packets addressed to this node and counts them in drop_cnt.
module packet_route_port #(
   parameter int WIDTH  = 9,
   parameter int DEPTH  = 4,
   parameter int X_ADDR = 0,
   parameter int Y_ADDR = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [4:0]             out_dir,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [7:0]             drop_cnt
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [1:0]  X_LOC    = 2'(X_ADDR);
   localparam logic [1:0]  Y_LOC    = 2'(Y_ADDR);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   localparam logic [4:0] DIR_LOCAL = 5'b00001;
   localparam logic [4:0] DIR_EAST  = 5'b00010;
   localparam logic [4:0] DIR_WEST  = 5'b00100;
   localparam logic [4:0] DIR_NORTH = 5'b01000;
   localparam logic [4:0] DIR_SOUTH = 5'b10000;

   // Both sides use valid/ready: a beat transfers on a rising edge where valid and
   // ready are both 1; valid never waits on ready, and a held beat stays stable until taken.

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [4:0]       dir_q, dir_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   logic [WIDTH-1:0] head;
   logic [1:0]       head_x, head_y;
   logic [4:0]       head_dir;
   logic             push, can_load, load, drop, self_hit;

   assign head   = mem_q[rd_ptr_q];
   assign head_x = head[WIDTH-2:WIDTH-3];
   assign head_y = head[WIDTH-4:WIDTH-5];

`ifdef SELF_DROP_EN
   assign self_hit = (head_x == X_LOC) && (head_y == Y_LOC);
`else
   assign self_hit = 1'b0;
`endif

   // Full is judged on the registered count only, so a pop cannot open in_ready in the same cycle.
   assign in_ready = (count_q < FULL_CNT);
   assign push     = in_valid && in_ready;
   assign can_load = (count_q != '0) && ((state_q == ST_EMPTY) || out_ready);
   assign load     = can_load && !self_hit;
   assign drop     = can_load && self_hit;

   always_comb begin
      head_dir = DIR_LOCAL;
      if (head_x > X_LOC)      head_dir = DIR_EAST;
      else if (head_x < X_LOC) head_dir = DIR_WEST;
      else if (head_y > Y_LOC) head_dir = DIR_NORTH;
      else if (head_y < Y_LOC) head_dir = DIR_SOUTH;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (can_load) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, can_load})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // A dropped head still consumes the pop slot, so a held beat that was taken leaves EMPTY.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      dir_d      = dir_q;
      drop_cnt_d = drop_cnt_q;
      if (load) begin
         state_d = ST_HOLD;
         data_d  = head;
         dir_d   = head_dir;
      end else if ((state_q == ST_HOLD) && out_ready) begin
         state_d = ST_EMPTY;
      end
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_EMPTY;
         data_q     <= '0;
         dir_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         data_q     <= data_d;
         dir_q      <= dir_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_valid  = (state_q == ST_HOLD);
   assign out_data   = data_q;
   assign out_dir    = dir_q;
   assign fifo_count = count_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_packet_route_port.sv
// Bench for packet_route_port at X=1, Y=2, WIDTH=9, DEPTH=4: directed vectors, queue scoreboard.
module tb_packet_route_port;

   localparam int WIDTH = 9;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [4:0]       out_dir;
   logic [CW-1:0]    fifo_count;
   logic [7:0]       drop_cnt;

   packet_route_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .X_ADDR(1),
      .Y_ADDR(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_dir   (out_dir),
      .fifo_count(fifo_count),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [13:0] exp_q[$];
   logic        prev_hold = 1'b0;
   logic [13:0] prev_out = '0;
   int          cyc = 0;
   int          last_pop_cyc = 0;
   int          stream_pops = 0;
   logic        stream_on = 1'b0;
   logic        fifo_mon = 1'b0;

   // Routing vectors and their hand-derived directions for node (1,2).
   logic [8:0] rv[4] = '{9'b0_11_10_0101, 9'b0_00_10_0001, 9'b0_01_11_0000, 9'b0_01_00_1111};
   logic [4:0] rd[4] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
   logic [8:0] self_pkt = 9'b0_01_10_0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic monitor();
      logic [13:0] exp;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_hold = 1'b0;
            continue;
         end
         if (prev_hold)
            check("hold_stable", 32'({out_valid, out_dir, out_data}), 32'({1'b1, prev_out}));
         if (fifo_mon)
            check("stream_fifo_le1", 32'(fifo_count <= CW'(1)), 32'(1));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'({out_dir, out_data}), 32'(0));
            end else begin
               exp = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(exp[8:0]));
               check("out_dir", 32'(out_dir), 32'(exp[13:9]));
               if (stream_on) begin
                  if (stream_pops > 0) check("one_per_edge", 32'(cyc - last_pop_cyc), 32'(1));
                  last_pop_cyc = cyc;
                  stream_pops++;
               end
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_out  = {out_dir, out_data};
      end
   endtask

   // Offers d until accepted; leaves in_valid high so calls can stream back to back.
   task automatic send(input logic [8:0] d, input logic [4:0] dir, input logic expect_out);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (n < 50) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
      end
      if (n >= 50) begin
         check("accept_timeout", 32'(0), 32'(1));
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (expect_out) exp_q.push_back({dir, d});
   endtask

   task automatic wait_drain();
      int n = 0;
      while (n < 200) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !out_valid) break;
         n++;
      end
      check("drain_done", 32'({exp_q.size() == 0, out_valid}), 32'(2'b10));
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Power-on reset, checked before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_fifo_count", 32'(fifo_count), 32'(0));
      check("rst_drop_cnt", 32'(drop_cnt), 32'(0));
      check("rst_out_data", 32'({out_dir, out_data}), 32'(0));

      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Routing with two-edge latency on the first packet.
      out_ready = 1'b1;
      send(rv[0], rd[0], 1'b1);
      in_valid = 1'b0;
      check("lat_edge_n", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
      check("lat_edge_n1", 32'(out_valid), 32'(1));
      for (int i = 1; i < 4; i++) send(rv[i], rd[i], 1'b1);
      in_valid = 1'b0;
      wait_drain();

      // Self-addressed packet.
`ifdef SELF_DROP_EN
      send(self_pkt, 5'b00001, 1'b0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("self_drop_cnt", 32'(drop_cnt), 32'(1));
      check("self_no_valid", 32'(out_valid), 32'(0));
      check("self_fifo_empty", 32'(fifo_count), 32'(0));
`else
      send(self_pkt, 5'b00001, 1'b1);
      in_valid = 1'b0;
      wait_drain();
      check("self_drop_cnt", 32'(drop_cnt), 32'(0));
`endif

      // Backpressure: one held plus four buffered, sixth refused.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send({rv[i % 4][8:4], 4'(i + 8)}, rd[i % 4], 1'b1);
      in_data = {rv[1][8:4], 4'hE};
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_fifo_count", 32'(fifo_count), 32'(4));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      @(posedge clk);
      #1;
      check("bp_refused", 32'(fifo_count), 32'(4));
      check("bp_no_bypass", 32'(in_ready), 32'(0));
      in_valid    = 1'b0;
      stream_pops = 0;
      stream_on   = 1'b1;
      out_ready   = 1'b1;
      wait_drain();
      stream_on = 1'b0;
      check("bp_pop_count", 32'(stream_pops), 32'(5));

      // Streaming 20 packets with both sides always ready.
      stream_pops = 0;
      stream_on   = 1'b1;
      fifo_mon    = 1'b1;
      for (int i = 0; i < 20; i++) send({rv[i % 4][8:4], 4'(i)}, rd[i % 4], 1'b1);
      in_valid = 1'b0;
      wait_drain();
      stream_on = 1'b0;
      fifo_mon  = 1'b0;
      check("stream_pop_count", 32'(stream_pops), 32'(20));

      // Reset mid-traffic: buffered and held packets are discarded without a clock edge.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(rv[i], rd[i], 1'b1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'(0));
      check("mid_rst_fifo_count", 32'(fifo_count), 32'(0));
      check("mid_rst_drop_cnt", 32'(drop_cnt), 32'(0));
      check("mid_rst_in_ready", 32'(in_ready), 32'(1));
      check("mid_rst_out_regs", 32'({out_dir, out_data}), 32'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_no_stale", 32'({out_valid, fifo_count}), 32'(0));
      send(rv[3], rd[3], 1'b1);
      in_valid = 1'b0;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
